// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: start strobe, operands, status and results.
// The master side issues divisions; the slave side (the divider) returns results.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift-subtract step per clock, WIDTH steps per divide.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise unsigned only and ovf is tied 0.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             dz_pend;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_zero_r;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    logic accept;

    // Iteration runs on magnitudes; the signed build restores signs at the final edge.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
`ifdef DIV_SIGNED_EN
        return x[WIDTH-1] ? (~x + 1'b1) : x;
`else
        return x;
`endif
    endfunction

    assign accept = bus.start && (state != S_RUN);

    // One restoring step: shift {P,Q} left, subtract the divisor if it fits.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        p_shift = {p_reg, q_reg[WIDTH-1]};
        p_next  = p_shift[WIDTH-1:0];
        q_next  = {q_reg[WIDTH-2:0], 1'b0};
        if (p_shift >= {1'b0, dvs_mag}) begin
            p_next    = p_shift[WIDTH-1:0] - dvs_mag;
            q_next[0] = 1'b1;
        end
    end

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovf_r;
    logic ovf_final;

    // Only |most-negative| / 1 with a positive result lands on the quotient MSB.
    always_comb begin
        q_final   = neg_q ? (~q_next + 1'b1) : q_next;
        r_final   = neg_r ? (~p_next + 1'b1) : p_next;
        ovf_final = ~neg_q & q_next[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r <= bus.dividend[WIDTH-1];
            ovf_r <= 1'b0;
        end else if (state == S_RUN && !dz_pend && step_cnt == LAST_STEP) begin
            ovf_r <= ovf_final;
        end
    end

    assign bus.ovf = ovf_r;
`else
    always_comb begin
        q_final = q_next;
        r_final = p_next;
    end

    assign bus.ovf = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            step_cnt    <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            dz_pend     <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state      <= S_RUN;
                        step_cnt   <= '0;
                        p_reg      <= '0;
                        q_reg      <= magnitude(bus.dividend);
                        dvs_mag    <= magnitude(bus.divisor);
                        dvd_raw    <= bus.dividend;
                        dz_pend    <= (bus.divisor == '0);
                        div_zero_r <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (dz_pend) begin
                        // Divide by zero skips iteration entirely: result one edge after accept.
                        quotient_r  <= '1;
                        remainder_r <= dvd_raw;
                        div_zero_r  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        p_reg    <= p_next;
                        q_reg    <= q_next;
                        step_cnt <= step_cnt + 1'b1;
                        if (step_cnt == LAST_STEP) begin
                            quotient_r  <= q_final;
                            remainder_r <= r_final;
                            state       <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == S_RUN);
    assign bus.done      = (state == S_DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner sequences,
// and random operands against an arithmetic reference model (honours DIV_SIGNED_EN).
module tb_seq_divider;
    localparam int W       = 4;
    localparam int TIMEOUT = 20;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero and overflow rules.
    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        result_t res;
        int sa;
        int sb;
        int sq;
        int sr;
        res.dz  = (b == '0);
        res.ovf = 1'b0;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            sq = sa / sb;
            sr = sa % sb;
            if (sq > (2 ** W) - 1 || (sa < 0 && sq > (2 ** (W - 1)) - 1)) begin
                res.ovf = 1'b1;
                res.q   = {1'b1, {(W-1){1'b0}}};
                res.r   = '0;
            end else begin
                res.q = sq[W-1:0];
                res.r = sr[W-1:0];
            end
        end
        return res;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic hold_start,
                          output int edges);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        edges = 0;
        while (!bus.done && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int edges);
        result_t exp;
        exp = model(a, b);
        check({tag, "_latency"}, edges, (b == '0) ? 1 : W);
        check({tag, "_quotient"}, bus.quotient, exp.q);
        check({tag, "_remainder"}, bus.remainder, exp.r);
        check({tag, "_div_zero"}, bus.div_zero, exp.dz);
        check({tag, "_ovf"}, bus.ovf, exp.ovf);
    endtask

    initial begin
        vec_t    vecs[12];
        result_t exp;
        int      edges;
        int      pulses;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

`ifdef DIV_SIGNED_EN
        vecs[0]  = '{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, 1'b1};
        vecs[2]  = '{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 4'd1,    4'b1000, 4'd0,    1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 4'd2,    4'b1100, 4'd0,    1'b0, 1'b0};
        vecs[5]  = '{4'd5,    4'd3,    4'd1,    4'd2,    1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 4'd4,    4'd0,    4'b1111, 1'b0, 1'b0};
        vecs[7]  = '{4'b1011, 4'd0,    4'hF,    4'b1011, 1'b1, 1'b0};
        vecs[8]  = '{4'd6,    4'b1101, 4'b1110, 4'd0,    1'b0, 1'b0};
        vecs[9]  = '{4'b1000, 4'b1000, 4'd1,    4'd0,    1'b0, 1'b0};
        vecs[10] = '{4'd7,    4'd7,    4'd1,    4'd0,    1'b0, 1'b0};
        vecs[11] = '{4'b1010, 4'b1100, 4'd1,    4'b1110, 1'b0, 1'b0};
`else
        vecs[0]  = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b0};
        vecs[1]  = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1, 1'b0};
        vecs[2]  = '{4'd15, 4'd4,  4'd3,  4'd3, 1'b0, 1'b0};
        vecs[3]  = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'd6,  4'd3,  4'd2,  4'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'd14, 4'd5,  4'd2,  4'd4, 1'b0, 1'b0};
        vecs[6]  = '{4'd15, 4'd1,  4'hF,  4'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 1'b0};
        vecs[10] = '{4'd1,  4'd0,  4'hF,  4'd1, 1'b1, 1'b0};
        vecs[11] = '{4'd8,  4'd15, 4'd0,  4'd8, 1'b0, 1'b0};
`endif

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_div_zero", bus.div_zero, 0);
        check("reset_ovf", bus.ovf, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, edges);
            check($sformatf("vec%0d_latency", i), edges, (vecs[i].dz) ? 1 : W);
            check($sformatf("vec%0d_quotient", i), bus.quotient, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), bus.remainder, vecs[i].r);
            check($sformatf("vec%0d_div_zero", i), bus.div_zero, vecs[i].dz);
            check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), bus.done, 0);
            check($sformatf("vec%0d_quotient_held", i), bus.quotient, vecs[i].q);
        end

        // Start pulsed mid-run must not disturb the in-flight 15/4.
        @(negedge clk);
        bus.dividend = 4'd15;
        bus.divisor  = 4'd4;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 2) begin
                bus.dividend = 4'd1;
                bus.divisor  = 4'd1;
                bus.start    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check_result("ignored_start", 4'd15, 4'd4, edges);
        @(posedge clk);
        #1;

        // Start held through done: 6/3 accepted straight out of DONE.
        run_op(4'd9, 4'd2, 1'b1, edges);
        check_result("b2b_first", 4'd9, 4'd2, edges);
        bus.dividend = 4'd6;
        bus.divisor  = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_no_idle_gap", bus.busy, 1);
        edges = 0;
        while (!bus.done && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_result("b2b_second", 4'd6, 4'd3, edges);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of 14/5.
        @(negedge clk);
        bus.dividend = 4'd14;
        bus.divisor  = 4'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_div_zero", bus.div_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_op(4'd14, 4'd5, 1'b0, edges);
        check_result("after_rst", 4'd14, 4'd5, edges);

        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(ra, rb, 1'b0, edges);
            exp = model(ra, rb);
            check($sformatf("rand%0d_latency", n), edges, (rb == '0) ? 1 : W);
            check($sformatf("rand%0d_quotient", n), bus.quotient, exp.q);
            check($sformatf("rand%0d_remainder", n), bus.remainder, exp.r);
            check($sformatf("rand%0d_flags", n), {bus.div_zero, bus.ovf}, {exp.dz, exp.ovf});
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
